boot_loader: RTL



---
 rtl/boot_pkg.sv | 7 +
 rtl/boot_timeout.sv | 17 +
 rtl/boot_loader.sv | 99 +++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// boot_pkg: shared constants and FSM state encoding for the serial boot loader
package boot_pkg;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int MAX_WORDS = 16384;
  localparam int IM_ADDR_W = 14;
  typedef enum logic [2:0] {IDLE, CNT_H, CNT_L, DAT_H, DAT_L, CHK, DONE, ERR} state_t;
endpackage

// File: rtl/boot_timeout.sv
// boot_timeout: idle counter (clk, rst_n, en, clr in; expired out), held at 0 while en=0, cleared by clr, saturates at TIMEOUT
module boot_timeout #(
  parameter int TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt;
  assign expired = cnt == W'(TIMEOUT);
  always_ff @(posedge clk)
    if (!rst_n || clr || !en) cnt <= '0;
    else if (!expired) cnt <= cnt + W'(1);
endmodule

// File: rtl/boot_loader.sv
// boot_loader: UART byte stream (rx_data/rx_vld) to framed, checksummed 16-bit instruction-memory writes (im_addr/im_wdata/im_dbg); status cpu_rst_n/busy/done/err
module boot_loader
  import boot_pkg::*;
#(
  parameter int TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_vld,
  output logic [15:0] im_addr,
  output logic [15:0] im_wdata,
  output logic        im_dbg,
  output logic        cpu_rst_n,
  output logic        busy,
  output logic        done,
  output logic        err
);
  state_t state, state_n;
  logic [7:0] hi, hi_n, sum, sum_n;
  logic [IM_ADDR_W:0] n, n_n, idx, idx_n;
  logic [15:0] addr_n, wdata_n, wn;
  logic dbg_n, expired;
  assign busy = state inside {CNT_H, CNT_L, DAT_H, DAT_L, CHK};
  assign done = state == DONE;
  assign cpu_rst_n = state == DONE;
  assign err = state == ERR;
  assign wn = {hi, rx_data};
  boot_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk(clk),
    .rst_n(rst_n),
    .en(busy),
    .clr(rx_vld),
    .expired(expired)
  );
  always_comb begin
    state_n = state;
    hi_n = hi;
    sum_n = sum + rx_data;
    n_n = n;
    idx_n = idx;
    addr_n = im_addr;
    wdata_n = im_wdata;
    dbg_n = 1'b0;
    if (rx_vld)
      case (state)
        IDLE, ERR: begin
          sum_n = '0;
          idx_n = '0;
          state_n = rx_data == SYNC_BYTE ? CNT_H : state;
        end
        CNT_H: begin
          hi_n = rx_data;
          state_n = CNT_L;
        end
        CNT_L: begin
          n_n = wn[IM_ADDR_W:0];
          state_n = wn > 16'(MAX_WORDS) ? ERR : wn == '0 ? CHK : DAT_H;
        end
        DAT_H: begin
          hi_n = rx_data;
          state_n = DAT_L;
        end
        DAT_L: begin
          wdata_n = wn;
          addr_n = 16'(idx);
          dbg_n = 1'b1;
          idx_n = idx + 1'b1;
          state_n = idx_n == n ? CHK : DAT_H;
        end
        CHK: state_n = rx_data == sum ? DONE : ERR;
        default: sum_n = sum;
      endcase
    else begin
      sum_n = sum;
      state_n = expired ? ERR : state;
    end
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      hi <= '0;
      sum <= '0;
      n <= '0;
      idx <= '0;
      im_addr <= '0;
      im_wdata <= '0;
      im_dbg <= 1'b0;
    end else begin
      state <= state_n;
      hi <= hi_n;
      sum <= sum_n;
      n <= n_n;
      idx <= idx_n;
      im_addr <= addr_n;
      im_wdata <= wdata_n;
      im_dbg <= dbg_n;
    end
endmodule
